board_state_writer: RTL and testbench
=====================================

// Module: board_state_writer
// PURPOSE
//  Producer side of the 4x8 block-board interface consumed by the VGA display controller.
//  Game logic writes cells through a valid/ready command port into a shadow board.
//  column_0..column_3 present a frame-stable copy of the board. That copy is updated only at
//  vsync assertion, so a frame never tears. Sits between game FSM and display controller.
// PARAMETERS
//  NUM_ROWS   8   cells per column (fixed by 24-bit column bus, 3 bits/cell)
//  CELL_W     3   colour bits per cell; 3'b000 = empty
// PORTS
//  CLK_50M    in   1   system clock
//  RST_N      in   1   asynchronous, active-low reset
//  vsync      in   1   display vsync (active low, same clock domain, registered at source)
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   command accepted when cmd_valid & cmd_ready at a rising edge
//  cmd_op     in   2   00 WRITE, 01 CLEAR_CELL, 10 SHIFT_DOWN (column), 11 CLEAR_ALL
//  cmd_col    in   2   target column 0..3
//  cmd_row    in   3   target row 0 (top) .. 7 (bottom)
//  cmd_color  in   3   colour for WRITE
//  column_0..column_3  out  24 each  committed board; row r at bits [23-3r : 21-3r]
//  frame_tick out  1   one-cycle pulse on commit
// BEHAVIOUR
//  Reset: shadow and all column_N = 0, frame_tick = 0, FSM = IDLE, gravity_pending = 0.
//   Reset is honoured mid-operation (aborts CLR/GRAV).
//  cmd_ready = 1 only in IDLE (combinational from state).
//  WRITE / CLEAR_CELL / SHIFT_DOWN: single-cycle; shadow updated at the accept edge.
//   FSM stays IDLE.
//  SHIFT_DOWN: new[r] = old[r-1] for r=7..1, new[0] = 0; other columns untouched.
//  CLEAR_ALL: accept -> CLR state for 4 cycles, zeroing shadow column idx 0,1,2,3 in order.
//   Then -> IDLE. cmd_ready low for exactly those 4 cycles.
//  cmd_col/cmd_row are sampled only at accept. Inputs are ignored while cmd_ready = 0.
//  Commit: vsync_d <= vsync each cycle. Commit cycle = (vsync_d==1 && vsync==0).
//   At that edge column_N <= shadow value present before any same-edge command update.
//   A command accepted on the commit edge appears at the NEXT commit.
//   frame_tick = 1 for that one cycle.
//  Commit occurs in every FSM state, including mid-CLR; partially cleared board is committed.
//  Latency: command accepted at cycle t is visible on column_N at the first commit edge > t.
// CONFIGURATION
//  BOARD_GRAVITY_EN defined:
//   - Each commit sets gravity_pending.
//   - When IDLE with gravity_pending (and no cmd accepted that cycle), enter GRAV for 4
//     cycles. Each cycle processes one column idx 0..3; then clear pending and -> IDLE.
//   - Per column, one fall step, all rows simultaneously from old values:
//     new[r] = old[r]!=0 ? ((r<7 && old[r+1]==0) ? 0 : old[r]) : (r>0 ? old[r-1] : 0).
//   - cmd_ready low during GRAV. Commit arriving during GRAV re-sets pending.
//  BOARD_GRAVITY_EN undefined: no GRAV state, no pending flag; the board changes only by
//   commands.
// TESTING
//  1 Reset with RST_N low mid-CLR -> all column_N = 0, cmd_ready = 1 after release.
//  2 WRITE col2 row0 colour 3'b100, then vsync 1->0 -> column_2 = 24'h800000,
//    frame_tick single pulse, other columns 0.
//  3 WRITE col0 row7 colour 3'b001 on the same edge as commit -> column_0 stays 0 this frame;
//    becomes 24'h000001 at the next commit.
//  4 CLEAR_ALL with board full of 3'b111 -> cmd_ready low 4 cycles. Commit forced at CLR
//    cycle 2 -> column_0 = 0, column_1 = 0, column_2 = column_3 = 24'hFFFFFF.
//  5 col1 = rows0..2 colour 3'b010, SHIFT_DOWN col1 + commit -> column_1 = 24'h092000;
//    cmd_ready never drops.
//  6 BOARD_GRAVITY_EN: col3 row0 = 3'b100, 8 commits -> cell falls one row per frame,
//    rests at row7; column_3 = 24'h000004; GRAV lasts 4 cycles.

Source files
------------

// File: rtl/board_state_writer.sv
`default_nettype none
// ============================================================================
// board_state_writer : shadow 4x8 block board written by game logic, committed
// to the display copy at vsync assertion. Optional gravity: BOARD_GRAVITY_EN.
// Revision 1.0
// ============================================================================
module board_state_writer #(
  parameter int NUM_ROWS = 8,
  parameter int CELL_W   = 3
) (
  input  logic                       CLK_50M,
  input  logic                       RST_N,
  input  logic                       vsync,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [1:0]                 cmd_col,
  input  logic [2:0]                 cmd_row,
  input  logic [CELL_W-1:0]          cmd_color,
  output logic [NUM_ROWS*CELL_W-1:0] column_0,
  output logic [NUM_ROWS*CELL_W-1:0] column_1,
  output logic [NUM_ROWS*CELL_W-1:0] column_2,
  output logic [NUM_ROWS*CELL_W-1:0] column_3,
  output logic                       frame_tick
);

  localparam int COL_W = NUM_ROWS * CELL_W;

  localparam logic [1:0] OP_WRITE      = 2'b00;
  localparam logic [1:0] OP_CLEAR_CELL = 2'b01;
  localparam logic [1:0] OP_SHIFT_DOWN = 2'b10;
  localparam logic [1:0] OP_CLEAR_ALL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLR  = 2'd1;
`ifdef BOARD_GRAVITY_EN
  localparam logic [1:0] ST_GRAV = 2'd2;
`endif

  logic [1:0]       state;
  logic [1:0]       idx;
  logic             vsync_d;
  logic [COL_W-1:0] shadow [4];
  logic             commit;
  logic             accept;
`ifdef BOARD_GRAVITY_EN
  logic             gravity_pending;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign commit    = vsync_d & ~vsync;

  // Row 0 sits in the most significant cell of the column word.
  function automatic logic [COL_W-1:0] set_cell(input logic [COL_W-1:0] col,
                                                input logic [2:0]       row,
                                                input logic [CELL_W-1:0] val);
    logic [COL_W-1:0] result;
    result = col;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (3'(r) == row) result[COL_W-1-CELL_W*r -: CELL_W] = val;
    end
    return result;
  endfunction

`ifdef BOARD_GRAVITY_EN
  // Padded view: an empty cell above row 0 and a solid floor below the last row.
  function automatic logic [COL_W-1:0] fall_step(input logic [COL_W-1:0] col);
    logic [CELL_W-1:0] p [NUM_ROWS+2];
    logic [COL_W-1:0]  result;
    p[0]          = '0;
    p[NUM_ROWS+1] = '1;
    for (int r = 0; r < NUM_ROWS; r++) p[r+1] = col[COL_W-1-CELL_W*r -: CELL_W];
    result = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (p[r+1] != '0) result[COL_W-1-CELL_W*r -: CELL_W] = (p[r+2] == '0) ? '0 : p[r+1];
      else              result[COL_W-1-CELL_W*r -: CELL_W] = p[r];
    end
    return result;
  endfunction
`endif

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      idx        <= 2'd0;
      vsync_d    <= 1'b0;
      frame_tick <= 1'b0;
      column_0   <= '0;
      column_1   <= '0;
      column_2   <= '0;
      column_3   <= '0;
      for (int c = 0; c < 4; c++) shadow[c] <= '0;
`ifdef BOARD_GRAVITY_EN
      gravity_pending <= 1'b0;
`endif
    end else begin
      vsync_d    <= vsync;
      frame_tick <= commit;
      // Non-blocking reads give the pre-update shadow even if a command lands this edge.
      if (commit) begin
        column_0 <= shadow[0];
        column_1 <= shadow[1];
        column_2 <= shadow[2];
        column_3 <= shadow[3];
      end

      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (cmd_op)
              OP_WRITE:      shadow[cmd_col] <= set_cell(shadow[cmd_col], cmd_row, cmd_color);
              OP_CLEAR_CELL: shadow[cmd_col] <= set_cell(shadow[cmd_col], cmd_row, '0);
              OP_SHIFT_DOWN: shadow[cmd_col] <= {{CELL_W{1'b0}}, shadow[cmd_col][COL_W-1:CELL_W]};
              OP_CLEAR_ALL: begin
                state <= ST_CLR;
                idx   <= 2'd0;
              end
              default: ;
            endcase
          end
`ifdef BOARD_GRAVITY_EN
          else if (gravity_pending) begin
            state <= ST_GRAV;
            idx   <= 2'd0;
          end
`endif
        end
        ST_CLR: begin
          shadow[idx] <= '0;
          idx         <= idx + 2'd1;
          if (idx == 2'd3) state <= ST_IDLE;
        end
`ifdef BOARD_GRAVITY_EN
        ST_GRAV: begin
          shadow[idx] <= fall_step(shadow[idx]);
          idx         <= idx + 2'd1;
          if (idx == 2'd3) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase

`ifdef BOARD_GRAVITY_EN
      // A commit landing on the final gravity cycle keeps another pass queued.
      if (commit)                                     gravity_pending <= 1'b1;
      else if ((state == ST_GRAV) && (idx == 2'd3))   gravity_pending <= 1'b0;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_state_writer.sv
`default_nettype none
// Testbench for board_state_writer: directed scenarios plus random traffic against a
// cell-array reference model with a queue of pending per-column jobs.
module tb_board_state_writer;

  logic        CLK_50M   = 1'b0;
  logic        RST_N     = 1'b0;
  logic        vsync     = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op    = 2'b00;
  logic [1:0]  cmd_col   = 2'b00;
  logic [2:0]  cmd_row   = 3'b000;
  logic [2:0]  cmd_color = 3'b000;
  logic        cmd_ready;
  logic        frame_tick;
  logic [23:0] column_0, column_1, column_2, column_3;

  board_state_writer dut (
    .CLK_50M   (CLK_50M),
    .RST_N     (RST_N),
    .vsync     (vsync),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_col   (cmd_col),
    .cmd_row   (cmd_row),
    .cmd_color (cmd_color),
    .column_0  (column_0),
    .column_1  (column_1),
    .column_2  (column_2),
    .column_3  (column_3),
    .frame_tick(frame_tick)
  );

  always #10 CLK_50M = ~CLK_50M;

`ifdef BOARD_GRAVITY_EN
  localparam bit GRAV_ON = 1'b1;
`else
  localparam bit GRAV_ON = 1'b0;
`endif

  typedef struct packed {
    logic       grav;
    logic [1:0] col;
  } job_t;

  logic [2:0]  m_board [4][8];
  logic [23:0] m_shown [4];
  logic        m_tick;
  logic        m_vprev;
  logic        m_pending;
  job_t        m_jobs [$];

  int n_assert = 0;
  int n_fail   = 0;

  function automatic logic [23:0] pack_col(input int c);
    logic [23:0] v;
    v = '0;
    for (int r = 0; r < 8; r++) v[23-3*r -: 3] = m_board[c][r];
    return v;
  endfunction

  function automatic void model_fall(input int c);
    logic [2:0] old [8];
    for (int r = 0; r < 8; r++) old[r] = m_board[c][r];
    for (int r = 0; r < 8; r++) begin
      if (old[r] != 3'd0) begin
        m_board[c][r] = old[r];
        if (r < 7) begin
          if (old[r+1] == 3'd0) m_board[c][r] = 3'd0;
        end
      end else begin
        m_board[c][r] = (r > 0) ? old[r-1] : 3'd0;
      end
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_shown[c] = '0;
      for (int r = 0; r < 8; r++) m_board[c][r] = 3'd0;
    end
    m_tick    = 1'b0;
    m_vprev   = 1'b0;
    m_pending = 1'b0;
    m_jobs.delete();
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    bit   ready, commit, accepted, old_pending;
    job_t j;
    ready       = (m_jobs.size() == 0);
    commit      = m_vprev && !vsync;
    accepted    = cmd_valid && ready;
    old_pending = m_pending;
    m_tick      = commit;
    if (commit) for (int c = 0; c < 4; c++) m_shown[c] = pack_col(c);
    if (!ready) begin
      j = m_jobs.pop_front();
      if (j.grav) model_fall(int'(j.col));
      else for (int r = 0; r < 8; r++) m_board[j.col][r] = 3'd0;
      if (j.grav && m_jobs.size() == 0 && !commit) m_pending = 1'b0;
    end else if (accepted) begin
      case (cmd_op)
        2'b00: m_board[cmd_col][cmd_row] = cmd_color;
        2'b01: m_board[cmd_col][cmd_row] = 3'd0;
        2'b10: begin
          for (int r = 7; r > 0; r--) m_board[cmd_col][r] = m_board[cmd_col][r-1];
          m_board[cmd_col][0] = 3'd0;
        end
        default: for (int c = 0; c < 4; c++) m_jobs.push_back('{grav: 1'b0, col: 2'(c)});
      endcase
    end else if (old_pending) begin
      for (int c = 0; c < 4; c++) m_jobs.push_back('{grav: 1'b1, col: 2'(c)});
    end
    if (commit && GRAV_ON) m_pending = 1'b1;
    m_vprev = vsync;
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("column_0", column_0, m_shown[0]);
    chk("column_1", column_1, m_shown[1]);
    chk("column_2", column_2, m_shown[2]);
    chk("column_3", column_3, m_shown[3]);
    chk("frame_tick", {23'd0, frame_tick}, {23'd0, m_tick});
    chk("cmd_ready", {23'd0, cmd_ready}, {23'd0, m_jobs.size() == 0});
  endtask

  task automatic cycle();
    model_step();
    @(posedge CLK_50M);
    #1;
    check_all();
  endtask

  task automatic set_cmd(input logic v, input logic [1:0] op, input logic [1:0] col,
                         input logic [2:0] row, input logic [2:0] color);
    cmd_valid = v;
    cmd_op    = op;
    cmd_col   = col;
    cmd_row   = row;
    cmd_color = color;
  endtask

  task automatic quiet();
    for (int i = 0; i < 50; i++) begin
      if (m_jobs.size() == 0 && !m_pending) break;
      set_cmd(1'b0, 2'b00, 2'd0, 3'd0, 3'd0);
      vsync = 1'b1;
      cycle();
    end
  endtask

  int low_cnt;

  initial begin
    // Power-on reset
    model_reset();
    repeat (2) @(posedge CLK_50M);
    #1;
    check_all();
    #5 RST_N = 1'b1;

    // 1: reset asserted in the middle of a CLEAR_ALL
    set_cmd(1'b1, 2'b00, 2'd0, 3'd0, 3'd5); cycle();
    set_cmd(1'b1, 2'b00, 2'd3, 3'd4, 3'd6); cycle();
    set_cmd(1'b0, 2'b00, 2'd0, 3'd0, 3'd0); vsync = 1'b0; cycle();
    vsync = 1'b1; cycle();
    set_cmd(1'b1, 2'b11, 2'd0, 3'd0, 3'd0); cycle();
    set_cmd(1'b0, 2'b00, 2'd0, 3'd0, 3'd0); cycle(); cycle();
    #5 RST_N = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t1_col0_reset", column_0, 24'h000000);
    @(posedge CLK_50M);
    #1;
    check_all();
    #5 RST_N = 1'b1;
    cycle();
    chk("t1_ready_after_release", {23'd0, cmd_ready}, 24'd1);

    // 2: single write then commit
    set_cmd(1'b1, 2'b00, 2'd2, 3'd0, 3'b100); cycle();
    set_cmd(1'b0, 2'b00, 2'd0, 3'd0, 3'd0); vsync = 1'b0; cycle();
    chk("t2_column_2", column_2, 24'h800000);
    chk("t2_column_0", column_0, 24'h000000);
    chk("t2_tick_high", {23'd0, frame_tick}, 24'd1);
    cycle();
    chk("t2_tick_single", {23'd0, frame_tick}, 24'd0);

    // 3: write on the commit edge shows up one frame later
    quiet();
    set_cmd(1'b1, 2'b00, 2'd0, 3'd7, 3'b001); vsync = 1'b0; cycle();
    chk("t3_column_0_same_frame", column_0, 24'h000000);
    set_cmd(1'b0, 2'b00, 2'd0, 3'd0, 3'd0); vsync = 1'b1; cycle();
    quiet();
    vsync = 1'b0; cycle();
    chk("t3_column_0_next_frame", column_0, 24'h000001);
    vsync = 1'b1; cycle();

    // 4: CLEAR_ALL on a full board with a commit on the third clear cycle
    quiet();
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 8; r++) begin
        set_cmd(1'b1, 2'b00, 2'(c), 3'(r), 3'b111);
        cycle();
      end
    set_cmd(1'b1, 2'b11, 2'd0, 3'd0, 3'd0); cycle();
    chk("t4_ready_low_0", {23'd0, cmd_ready}, 24'd0);
    set_cmd(1'b0, 2'b00, 2'd0, 3'd0, 3'd0); cycle();
    chk("t4_ready_low_1", {23'd0, cmd_ready}, 24'd0);
    cycle();
    vsync = 1'b0; cycle();
    chk("t4_column_0", column_0, 24'h000000);
    chk("t4_column_1", column_1, 24'h000000);
    chk("t4_column_2", column_2, 24'hFFFFFF);
    chk("t4_column_3", column_3, 24'hFFFFFF);
    vsync = 1'b1; cycle();
    chk("t4_ready_back", {23'd0, cmd_ready}, 24'd1);

    // 5: SHIFT_DOWN a partly filled column
    quiet();
    for (int r = 0; r < 3; r++) begin
      set_cmd(1'b1, 2'b00, 2'd1, 3'(r), 3'b010);
      cycle();
    end
    set_cmd(1'b1, 2'b10, 2'd1, 3'd0, 3'd0); cycle();
    chk("t5_ready_kept", {23'd0, cmd_ready}, 24'd1);
    set_cmd(1'b0, 2'b00, 2'd0, 3'd0, 3'd0); vsync = 1'b0; cycle();
    chk("t5_column_1", column_1, 24'h092000);
    vsync = 1'b1; cycle();

`ifdef BOARD_GRAVITY_EN
    // 6: a single cell falls one row per frame and rests on the floor
    quiet();
    set_cmd(1'b1, 2'b00, 2'd3, 3'd0, 3'b100); cycle();
    set_cmd(1'b0, 2'b00, 2'd0, 3'd0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      vsync = 1'b0; cycle();
      chk("t6_column_3_frame", column_3, 24'h800000 >> (3 * k));
      vsync = 1'b1;
      low_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        cycle();
        if (!cmd_ready) low_cnt++;
      end
      if (k == 0) chk("t6_grav_cycles", 24'(low_cnt), 24'd4);
    end
    chk("t6_column_3_rest", column_3, 24'h000004);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 2'($urandom_range(0, 3));
      if (cmd_op == 2'b11 && $urandom_range(0, 3) != 0) cmd_op = 2'b00;
      cmd_col   = 2'($urandom_range(0, 3));
      cmd_row   = 3'($urandom_range(0, 7));
      cmd_color = 3'($urandom_range(0, 7));
      vsync     = ($urandom_range(0, 9) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
